// File: rtl/riscv_str_ops_issue_if.sv
// Bundle of the request, string-unit and response signals for the string-ops
// issue stage. The slave side belongs to the issue stage; the master side is
// the surrounding pipeline (EX stage, string-ops unit and writeback).
//
// Handshakes (request and response channels alike): a transfer happens on a
// rising edge where valid and ready are both high. Valid never depends
// combinationally on ready. Once raised by the issue stage, rsp_valid_o and
// its payload stay stable until the transfer or a flush/reset.
interface riscv_str_ops_issue_if #(
  parameter int TAG_WIDTH    = 5,
  parameter int STR_OP_WIDTH = 3
);
  // request channel from EX
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [STR_OP_WIDTH-1:0] req_operator_i;
  logic [31:0]             req_operand_i;
  logic [TAG_WIDTH-1:0]    req_tag_i;
  logic                    flush_i;
  // combinational string-ops unit
  logic                    str_enable_o;
  logic [STR_OP_WIDTH-1:0] str_operator_o;
  logic [31:0]             str_operand_o;
  logic [31:0]             str_result_i;
  // response channel to writeback
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [31:0]             rsp_result_o;
  logic [TAG_WIDTH-1:0]    rsp_tag_o;
  // status
  logic                    busy_o;
  logic [31:0]             op_count_o;
  logic                    dbg_state_o;

  modport slave (
    input  req_valid_i, req_operator_i, req_operand_i, req_tag_i, flush_i,
    input  str_result_i, rsp_ready_i,
    output req_ready_o, str_enable_o, str_operator_o, str_operand_o,
    output rsp_valid_o, rsp_result_o, rsp_tag_o, busy_o, op_count_o, dbg_state_o
  );

  modport master (
    output req_valid_i, req_operator_i, req_operand_i, req_tag_i, flush_i,
    output str_result_i, rsp_ready_i,
    input  req_ready_o, str_enable_o, str_operator_o, str_operand_o,
    input  rsp_valid_o, rsp_result_o, rsp_tag_o, busy_o, op_count_o, dbg_state_o
  );
endinterface

// File: rtl/riscv_str_ops_issue.sv
// Issue/response stage in front of the combinational string-ops unit.
// Requests are queued in a small FIFO; the head is presented to the unit for
// exactly one cycle, its result is captured and then held with the request's
// tag until writeback takes it. Operator codes pass through undecoded.
module riscv_str_ops_issue #(
  parameter int FIFO_DEPTH   = 2,
  parameter int TAG_WIDTH    = 5,
  parameter int STR_OP_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_str_ops_issue_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  // IDLE: may issue the FIFO head. RESP: holding a result for writeback.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // FIFO storage and bookkeeping
  logic [STR_OP_WIDTH-1:0] r_op_mem  [FIFO_DEPTH];
  logic [31:0]             r_opd_mem [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]    r_tag_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W:0]          r_count;

  // captured response
  logic [31:0]             r_rsp_result;
  logic [TAG_WIDTH-1:0]    r_rsp_tag;
  logic [31:0]             r_op_count;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_ready;
  logic                    w_push;
  logic                    w_issue;
  logic                    w_rsp_valid;
  logic                    w_rsp_fire;
  logic                    w_str_enable;
  logic [STR_OP_WIDTH-1:0] w_str_operator;
  logic [31:0]             w_str_operand;

  // Ready looks only at the registered occupancy, so a slot freed by a pop
  // in this same cycle cannot be reused until the next one.
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_ready     = !rst && !w_full && !bus.flush_i;
  assign w_push      = bus.req_valid_i && w_ready;
  assign w_rsp_valid = (r_state == ST_RESP);
  // A response transferred in a flush cycle has still been delivered.
  assign w_rsp_fire  = w_rsp_valid && bus.rsp_ready_i;

  // Next-state and string-unit drive; flush overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_issue        = 1'b0;
    w_str_enable   = 1'b0;
    w_str_operator = '0;
    w_str_operand  = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_issue        = 1'b1;
          w_str_enable   = 1'b1;
          w_str_operator = r_op_mem[r_rd_ptr];
          w_str_operand  = r_opd_mem[r_rd_ptr];
          w_state_nxt    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (bus.flush_i) begin
      w_issue        = 1'b0;
      w_str_enable   = 1'b0;
      w_str_operator = '0;
      w_str_operand  = '0;
      w_state_nxt    = ST_IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIFO payload write at the tail; storage needs no reset since the count
  // decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wr_ptr]  <= bus.req_operator_i;
      r_opd_mem[r_wr_ptr] <= bus.req_operand_i;
      r_tag_mem[r_wr_ptr] <= bus.req_tag_i;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Result/tag capture on the issue edge; held until the next issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
    end else if (w_issue) begin
      r_rsp_result <= bus.str_result_i;
      r_rsp_tag    <= r_tag_mem[r_rd_ptr];
    end
  end

  // Completed-response counter, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_rsp_fire) begin
      r_op_count <= r_op_count + 32'd1;
    end
  end

  assign bus.req_ready_o    = w_ready;
  assign bus.str_enable_o   = w_str_enable;
  assign bus.str_operator_o = w_str_operator;
  assign bus.str_operand_o  = w_str_operand;
  assign bus.rsp_valid_o    = w_rsp_valid;
  assign bus.rsp_result_o   = r_rsp_result;
  assign bus.rsp_tag_o      = r_rsp_tag;
  assign bus.busy_o         = !w_empty || (r_state != ST_IDLE);
  assign bus.op_count_o     = r_op_count;
  assign bus.dbg_state_o    = (r_state == ST_RESP);

  // The unit is never enabled on two consecutive cycles.
  a_enable_single: assert property (@(posedge clk) disable iff (rst)
    bus.str_enable_o |=> !bus.str_enable_o);

  // A stalled response keeps its payload steady.
  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    (w_rsp_valid && !bus.rsp_ready_i && !bus.flush_i) |=>
      (w_rsp_valid && $stable(r_rsp_result) && $stable(r_rsp_tag)));

  // Occupancy never exceeds the FIFO depth.
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    r_count <= FULL_CNT);

endmodule

// File: tb/tb_riscv_str_ops_issue.sv
// Bench for riscv_str_ops_issue: a behavioural string unit answers the DUT's
// issue port, accepted requests push {tag, result} to a scoreboard queue and
// every response handshake pops and compares.
module tb_riscv_str_ops_issue;
  localparam int FIFO_DEPTH   = 2;
  localparam int TAG_WIDTH    = 5;
  localparam int STR_OP_WIDTH = 3;
  localparam int W            = TAG_WIDTH + 32;

  localparam logic [STR_OP_WIDTH-1:0] OP_UPPER = 3'd0;
  localparam logic [STR_OP_WIDTH-1:0] OP_LOWER = 3'd1;
  localparam logic [STR_OP_WIDTH-1:0] OP_LEET  = 3'd2;
  localparam logic [STR_OP_WIDTH-1:0] OP_ROT13 = 3'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks    = 0;
  int failures  = 0;
  logic [W-1:0] exp_q[$];
  int en_cnt    = 0;
  logic prev_en = 1'b0;
  int cyc       = 0;
  bit stream_on = 1'b0;
  int stream_n  = 0;
  int last_hs   = 0;
  int en_before = 0;

  riscv_str_ops_issue_if #(.TAG_WIDTH(TAG_WIDTH), .STR_OP_WIDTH(STR_OP_WIDTH)) bus ();

  riscv_str_ops_issue #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TAG_WIDTH   (TAG_WIDTH),
    .STR_OP_WIDTH(STR_OP_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- behavioural string-ops unit ----------------
  function automatic logic [31:0] str_model(input logic [STR_OP_WIDTH-1:0] op,
                                            input logic [31:0] d);
    logic [31:0] r;
    logic [7:0]  c;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      c = d[i*8 +: 8];
      case (op)
        OP_UPPER: if (c >= 8'h61 && c <= 8'h7a) c = c - 8'h20;
        OP_LOWER: if (c >= 8'h41 && c <= 8'h5a) c = c + 8'h20;
        OP_LEET: begin
          case (c)
            8'h61:   c = 8'h34;
            8'h65:   c = 8'h33;
            8'h69:   c = 8'h31;
            8'h6f:   c = 8'h30;
            8'h73:   c = 8'h35;
            8'h74:   c = 8'h37;
            default: c = c;
          endcase
        end
        OP_ROT13: begin
          if (c >= 8'h61 && c <= 8'h7a)      c = 8'h61 + ((c - 8'h61 + 8'd13) % 8'd26);
          else if (c >= 8'h41 && c <= 8'h5a) c = 8'h41 + ((c - 8'h41 + 8'd13) % 8'd26);
        end
        default: c = ~c;
      endcase
      r[i*8 +: 8] = c;
    end
    return r;
  endfunction

  always_comb bus.str_result_i = str_model(bus.str_operator_o, bus.str_operand_o);

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_req(input logic [STR_OP_WIDTH-1:0] op, input logic [31:0] d,
                          input logic [TAG_WIDTH-1:0] t);
    int n = 0;
    bus.req_valid_i    = 1'b1;
    bus.req_operator_i = op;
    bus.req_operand_i  = d;
    bus.req_tag_i      = t;
    @(negedge clk);
    while (!bus.req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready_o) check_eq("req_timeout", 0, 1);
    else exp_q.push_back({t, str_model(op, d)});
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.busy_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || bus.busy_o) check_eq("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      if (bus.str_enable_o) begin
        en_cnt++;
        check_eq("en_single", prev_en, 0);
      end
      prev_en = bus.str_enable_o;
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp", {bus.rsp_tag_o, bus.rsp_result_o}, e);
        end
        if (stream_on) begin
          if (stream_n > 0) check_eq("cadence", cyc - last_hs, 2);
          last_hs = cyc;
          stream_n++;
        end
      end
      if (bus.flush_i) exp_q.delete();
    end else begin
      prev_en = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid_i    = 1'b0;
    bus.req_operator_i = '0;
    bus.req_operand_i  = '0;
    bus.req_tag_i      = '0;
    bus.flush_i        = 1'b0;
    bus.rsp_ready_i    = 1'b0;

    // reset / idle
    repeat (2) @(posedge clk);
    #1;
    check_eq("ready_in_rst", bus.req_ready_o, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_ready",   bus.req_ready_o, 1);
    check_eq("rst_en",      bus.str_enable_o, 0);
    check_eq("rst_op",      bus.str_operator_o, 0);
    check_eq("rst_operand", bus.str_operand_o, 0);
    check_eq("rst_valid",   bus.rsp_valid_o, 0);
    check_eq("rst_result",  bus.rsp_result_o, 0);
    check_eq("rst_tag",     bus.rsp_tag_o, 0);
    check_eq("rst_busy",    bus.busy_o, 0);
    check_eq("rst_count",   bus.op_count_o, 0);
    check_eq("idle_no_en",  en_cnt, 0);

    // single UPPER request
    bus.rsp_ready_i = 1'b1;
    send_req(OP_UPPER, 32'h64636261, 5'd3);
    check_eq("issue_en",      bus.str_enable_o, 1);
    check_eq("issue_operand", bus.str_operand_o, 32'h64636261);
    check_eq("issue_op",      bus.str_operator_o, OP_UPPER);
    @(posedge clk);
    #1;
    check_eq("single_valid",  bus.rsp_valid_o, 1);
    check_eq("single_result", bus.rsp_result_o, 32'h44434241);
    check_eq("single_tag",    bus.rsp_tag_o, 3);
    check_eq("single_en_off", bus.str_enable_o, 0);
    @(posedge clk);
    #1;
    check_eq("single_count",  bus.op_count_o, 1);
    check_eq("single_done",   bus.rsp_valid_o, 0);
    check_eq("single_busy",   bus.busy_o, 0);

    // backpressure and full FIFO
    bus.rsp_ready_i = 1'b0;
    send_req(OP_LOWER, 32'h44434241, 5'd1);
    send_req(OP_LEET,  32'h6f746965, 5'd2);
    send_req(3'd6,     32'h12345678, 5'd3);
    check_eq("bp_full_ready", bus.req_ready_o, 0);
    check_eq("bp_busy",       bus.busy_o, 1);
    check_eq("bp_dbg_state",  bus.dbg_state_o, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_valid",  bus.rsp_valid_o, 1);
      check_eq("bp_tag",    bus.rsp_tag_o, 1);
      check_eq("bp_result", bus.rsp_result_o, str_model(OP_LOWER, 32'h44434241));
      check_eq("bp_ready",  bus.req_ready_o, 0);
    end
    bus.rsp_ready_i = 1'b1;
    wait_drain();
    check_eq("bp_count", bus.op_count_o, 4);

    // flush with two queued and one pending response
    bus.rsp_ready_i = 1'b0;
    send_req(OP_UPPER, 32'h61626364, 5'd7);
    send_req(OP_LOWER, 32'h41424344, 5'd8);
    send_req(OP_ROT13, 32'h6e6f7071, 5'd9);
    en_before   = en_cnt;
    bus.flush_i = 1'b1;
    #1;
    check_eq("flush_ready", bus.req_ready_o, 0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    check_eq("flush_valid", bus.rsp_valid_o, 0);
    check_eq("flush_busy",  bus.busy_o, 0);
    check_eq("flush_count", bus.op_count_o, 4);
    repeat (4) @(posedge clk);
    #1;
    check_eq("flush_no_en",  en_cnt, en_before);
    check_eq("flush_count2", bus.op_count_o, 4);

    // response handshaken in the flush cycle still counts
    send_req(OP_UPPER, 32'h7a7a7a7a, 5'd10);
    @(posedge clk);
    #1;
    bus.rsp_ready_i = 1'b1;
    bus.flush_i     = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    check_eq("flush_hs_count", bus.op_count_o, 5);
    check_eq("flush_hs_valid", bus.rsp_valid_o, 0);

    // asynchronous reset while a response is pending
    bus.rsp_ready_i = 1'b0;
    send_req(OP_UPPER, 32'h61616161, 5'd4);
    @(posedge clk);
    #1;
    check_eq("pre_rst_valid", bus.rsp_valid_o, 1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", bus.rsp_valid_o, 0);
    check_eq("arst_count", bus.op_count_o, 0);
    check_eq("arst_busy",  bus.busy_o, 0);
    check_eq("arst_ready", bus.req_ready_o, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("post_rst_result", bus.rsp_result_o, 0);
    check_eq("post_rst_valid",  bus.rsp_valid_o, 0);

    // streaming ROT13 with pointer wrap
    bus.rsp_ready_i = 1'b1;
    stream_on       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_req(OP_ROT13, $urandom, 5'(i + 16));
    end
    wait_drain();
    stream_on = 1'b0;
    check_eq("stream_count", bus.op_count_o, 10);
    check_eq("stream_n",     stream_n, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    check_eq("watchdog", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
